fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one FIFO write port (wr_en/data/full) among NUM_REQ requesters. Each requester has a valid/ready handshake. A grant is held for a burst of up to MAX_BURST beats, or until the requester signals last or drops valid. The block sits between producer blocks and the write domain of a shared FIFO, on the FIFO write clock.

---
 rtl/fifo_wr_arbiter_if.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester and FIFO write-port signals shared by fifo_wr_arbiter.
//
// Handshake: a requester beat transfers on a cycle where i_req_valid[k] and
// o_req_ready[k] are both high at the rising clock edge. A requester that
// raises valid keeps it (and its data) stable until ready; i_req_last[k] only
// carries meaning on a transferring beat. On the FIFO side o_fifo_wr_en is
// asserted exactly on transferring cycles, never while i_fifo_full is high.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_DATA = 8
);
  logic [NUM_REQ-1:0]           i_req_valid;
  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data;
  logic [NUM_REQ-1:0]           i_req_last;
  logic [NUM_REQ-1:0]           o_req_ready;
  logic                         i_fifo_full;
  logic                         o_fifo_wr_en;
  logic [SIZE_DATA-1:0]         o_fifo_data;
  logic [NUM_REQ-1:0]           o_grant;
  logic                         o_busy;

  // Producer/FIFO side: drives requests and the full flag.
  modport master (
    output i_req_valid, i_req_data, i_req_last, i_fifo_full,
    input  o_req_ready, o_fifo_wr_en, o_fifo_data, o_grant, o_busy
  );

  // Arbiter side.
  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_fifo_full,
    output o_req_ready, o_fifo_wr_en, o_fifo_data, o_grant, o_busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant lasts up to MAX_BURST beats, or ends early on last or dropped valid;
// a new winner is loaded on the release edge so bursts run back-to-back.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_DATA = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  fifo_wr_arbiter_if.slave           bus,
  output logic                       o_dbg_state,
  output logic [$clog2(NUM_REQ)-1:0] o_dbg_ptr
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PW-1:0]     ptr_q;
  logic [CW-1:0]     beat_q;

  logic [PW-1:0]      g_idx;
  logic               g_valid;
  logic               g_last;
  logic               xfer;
  logic [CW-1:0]      beat_next;
  logic               rel_last;
  logic               rel_max;
  logic               rel_drop;
  logic               rel_any;
  logic [PW-1:0]      ptr_next;
  logic [NUM_REQ-1:0] rearb_mask;
  logic [NUM_REQ-1:0] rearb_win;
  logic [NUM_REQ-1:0] idle_win;

  // First set bit of req scanning upward from start, wrapping modulo NUM_REQ.
  function automatic logic [NUM_REQ-1:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [PW-1:0]      start
  );
    logic [NUM_REQ-1:0] pick;
    logic               found;
    logic [PW-1:0]      idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(start) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  // Index of the currently granted requester (0 when nothing is granted).
  always_comb begin
    g_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) g_idx = PW'(k);
    end
  end

  // Ready follows the grant; reset blocks any write in the reset cycle itself.
  assign bus.o_req_ready  = grant_q & {NUM_REQ{~bus.i_fifo_full & ~i_rst}};
  assign xfer             = |(bus.i_req_valid & bus.o_req_ready);
  assign bus.o_fifo_wr_en = xfer;
  assign bus.o_fifo_data  = bus.i_req_data[int'(g_idx)*SIZE_DATA +: SIZE_DATA];
  assign bus.o_grant      = grant_q;
  assign bus.o_busy       = (state_q == ST_GRANT);
  assign o_dbg_state      = state_q;
  assign o_dbg_ptr        = ptr_q;

  assign g_valid   = bus.i_req_valid[g_idx];
  assign g_last    = bus.i_req_last[g_idx];
  assign beat_next = beat_q + CW'(1);

  // Release on last beat, on reaching the burst limit, or on dropped valid.
  assign rel_last = xfer & g_last;
  assign rel_max  = xfer & (beat_next == CW'(MAX_BURST));
  assign rel_drop = ~g_valid;
  assign rel_any  = (state_q == ST_GRANT) & (rel_last | rel_max | rel_drop);

  // Next round starts after the releasing requester; one that dropped valid
  // is left out of the same-cycle re-arbitration.
  assign ptr_next   = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + PW'(1);
  assign rearb_mask = bus.i_req_valid & ~(rel_drop ? grant_q : '0);
  assign rearb_win  = rr_pick(rearb_mask, ptr_next);
  assign idle_win   = rr_pick(bus.i_req_valid, ptr_q);

  // Grant FSM: state, one-hot grant, priority pointer and beat count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|bus.i_req_valid) begin
            grant_q <= idle_win;
            state_q <= ST_GRANT;
            beat_q  <= '0;
          end
        end
        ST_GRANT: begin
          if (rel_any) begin
            ptr_q   <= ptr_next;
            beat_q  <= '0;
            grant_q <= rearb_win;
            if (rearb_win == '0) state_q <= ST_IDLE;
          end else if (xfer) begin
            beat_q <= beat_next;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester beat sources, an expected
// FIFO write queue and per-cycle checks of grant, ready and write enable.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int SIZE_DATA = 8;
  localparam int MAX_BURST = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       o_dbg_state;
  logic [1:0] o_dbg_ptr;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .SIZE_DATA(SIZE_DATA)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .SIZE_DATA(SIZE_DATA),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .bus        (bus),
    .o_dbg_state(o_dbg_state),
    .o_dbg_ptr  (o_dbg_ptr)
  );

  // Clock and reset
  always #5 i_clk = ~i_clk;

  // Scoreboard state
  logic [SIZE_DATA-1:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  // Requester sources: bit SIZE_DATA is the last marker
  logic [SIZE_DATA:0] src_mem [NUM_REQ][16];
  int                 src_len [NUM_REQ];
  int                 src_head[NUM_REQ];
  logic               full_drv;

  // Values observed at the falling edge of the latest cycle
  logic [NUM_REQ-1:0] obs_grant;
  logic [NUM_REQ-1:0] obs_ready;
  logic               obs_busy;
  logic               obs_wr;
  logic [1:0]         obs_ptr;
  logic               obs_state;

  logic [NUM_REQ-1:0] t2_order [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int k, input logic [SIZE_DATA-1:0] d0,
                      input logic [SIZE_DATA-1:0] inc, input int n, input bit last_end);
    logic [SIZE_DATA-1:0] d;
    d = d0;
    for (int i = 0; i < n; i++) begin
      src_mem[k][i] = {(last_end && (i == n - 1)), d};
      d = d + inc;
    end
    src_head[k] = 0;
    src_len[k]  = n;
  endtask

  task automatic push_seq(input logic [SIZE_DATA-1:0] d0, input logic [SIZE_DATA-1:0] inc,
                          input int n);
    logic [SIZE_DATA-1:0] d;
    d = d0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d);
      d = d + inc;
    end
  endtask

  // Driver: present each requester's head beat, or idle if its source is empty
  task automatic drive();
    logic [NUM_REQ-1:0]           v;
    logic [NUM_REQ-1:0]           l;
    logic [NUM_REQ*SIZE_DATA-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (src_head[k] < src_len[k]) begin
        v[k] = 1'b1;
        l[k] = src_mem[k][src_head[k]][SIZE_DATA];
        d[k*SIZE_DATA +: SIZE_DATA] = src_mem[k][src_head[k]][SIZE_DATA-1:0];
      end
    end
    bus.i_req_valid = v;
    bus.i_req_last  = l;
    bus.i_req_data  = d;
    bus.i_fifo_full = full_drv;
  endtask

  // One clock cycle: drive, sample at the falling edge, score writes, advance sources
  task automatic cycle();
    drive();
    @(negedge i_clk);
    obs_grant = bus.o_grant;
    obs_ready = bus.o_req_ready;
    obs_busy  = bus.o_busy;
    obs_wr    = bus.o_fifo_wr_en;
    obs_ptr   = o_dbg_ptr;
    obs_state = o_dbg_state;
    check("wr_while_full", 32'(obs_wr & full_drv), 0);
    check("ready_outside_grant", 32'(obs_ready & ~obs_grant), 0);
    check("wr_en_vs_transfer", 32'(obs_wr), 32'(|(bus.i_req_valid & obs_ready)));
    if (obs_wr) begin
      check("unexpected_write", 32'(exp_q.size() == 0), 0);
      if (exp_q.size() > 0) check("fifo_data", 32'(bus.o_fifo_data), 32'(exp_q.pop_front()));
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (bus.i_req_valid[k] && obs_ready[k]) src_head[k]++;
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    t2_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < NUM_REQ; k++) begin
      src_len[k]  = 0;
      src_head[k] = 0;
    end
    full_drv = 1'b0;

    // Reset state
    repeat (3) cycle();
    check("rst_grant", 32'(obs_grant), 0);
    check("rst_busy", 32'(obs_busy), 0);
    check("rst_wr_en", 32'(obs_wr), 0);
    check("rst_ready", 32'(obs_ready), 0);
    check("rst_ptr", 32'(obs_ptr), 0);
    check("rst_state", 32'(obs_state), 0);
    i_rst = 1'b0;

    // All four requesters continuously valid: rotation 0,1,2,3,0
    load(0, 8'h10, 8'h00, 8, 1'b0);
    load(1, 8'h11, 8'h00, 4, 1'b0);
    load(2, 8'h12, 8'h00, 4, 1'b0);
    load(3, 8'h13, 8'h00, 4, 1'b0);
    push_seq(8'h10, 8'h00, 4);
    push_seq(8'h11, 8'h00, 4);
    push_seq(8'h12, 8'h00, 4);
    push_seq(8'h13, 8'h00, 4);
    push_seq(8'h10, 8'h00, 4);
    cycle();
    check("t2_idle_grant", 32'(obs_grant), 0);
    for (int b = 0; b < 20; b++) begin
      cycle();
      check("t2_wr_en", 32'(obs_wr), 1);
      check("t2_grant", 32'(obs_grant), 32'(t2_order[b/4]));
    end
    cycle();
    check("t2_regrant0", 32'(obs_grant), 32'h1);
    check("t2_regrant_no_wr", 32'(obs_wr), 0);
    cycle();
    check("t2_end_grant", 32'(obs_grant), 0);
    check("t2_end_busy", 32'(obs_busy), 0);
    check("t2_end_ptr", 32'(obs_ptr), 1);
    check("t2_drained", 32'(exp_q.size()), 0);

    // Only req0, six beats with last on the sixth
    load(0, 8'h01, 8'h01, 6, 1'b1);
    push_seq(8'h01, 8'h01, 6);
    cycle();
    check("t1_idle_grant", 32'(obs_grant), 0);
    for (int b = 0; b < 6; b++) begin
      cycle();
      check("t1_wr_en", 32'(obs_wr), 1);
      check("t1_grant", 32'(obs_grant), 32'h1);
    end
    cycle();
    check("t1_tail_grant", 32'(obs_grant), 32'h1);
    check("t1_tail_wr", 32'(obs_wr), 0);
    cycle();
    check("t1_end_grant", 32'(obs_grant), 0);
    check("t1_end_busy", 32'(obs_busy), 0);
    check("t1_end_ptr", 32'(obs_ptr), 1);
    check("t1_drained", 32'(exp_q.size()), 0);

    // req1 stalled by full for five cycles after beat 2
    load(1, 8'h21, 8'h01, 4, 1'b0);
    push_seq(8'h21, 8'h01, 4);
    cycle();
    check("t3_idle_grant", 32'(obs_grant), 0);
    repeat (2) begin
      cycle();
      check("t3_pre_wr", 32'(obs_wr), 1);
      check("t3_pre_grant", 32'(obs_grant), 32'h2);
    end
    full_drv = 1'b1;
    repeat (5) begin
      cycle();
      check("t3_full_wr", 32'(obs_wr), 0);
      check("t3_full_ready", 32'(obs_ready), 0);
      check("t3_full_grant", 32'(obs_grant), 32'h2);
    end
    full_drv = 1'b0;
    repeat (2) begin
      cycle();
      check("t3_post_wr", 32'(obs_wr), 1);
      check("t3_post_grant", 32'(obs_grant), 32'h2);
    end
    cycle();
    check("t3_tail_wr", 32'(obs_wr), 0);
    cycle();
    check("t3_end_grant", 32'(obs_grant), 0);
    check("t3_end_ptr", 32'(obs_ptr), 2);
    check("t3_drained", 32'(exp_q.size()), 0);

    // Pointer at 2: req2 single last beat, then req0 with no bubble
    load(2, 8'h41, 8'h00, 1, 1'b1);
    load(0, 8'h42, 8'h00, 1, 1'b1);
    push_seq(8'h41, 8'h00, 1);
    push_seq(8'h42, 8'h00, 1);
    cycle();
    check("t4_idle_grant", 32'(obs_grant), 0);
    cycle();
    check("t4_grant2", 32'(obs_grant), 32'h4);
    check("t4_wr2", 32'(obs_wr), 1);
    cycle();
    check("t4_grant0", 32'(obs_grant), 32'h1);
    check("t4_wr0", 32'(obs_wr), 1);
    check("t4_ptr3", 32'(obs_ptr), 3);
    cycle();
    check("t4_tail_wr", 32'(obs_wr), 0);
    cycle();
    check("t4_end_grant", 32'(obs_grant), 0);
    check("t4_end_ptr", 32'(obs_ptr), 1);
    check("t4_drained", 32'(exp_q.size()), 0);

    // req1 drops valid after one beat while req3 waits
    load(1, 8'h51, 8'h00, 1, 1'b0);
    load(3, 8'h61, 8'h01, 2, 1'b1);
    push_seq(8'h51, 8'h00, 1);
    push_seq(8'h61, 8'h01, 2);
    cycle();
    check("t6_idle_grant", 32'(obs_grant), 0);
    cycle();
    check("t6_grant1", 32'(obs_grant), 32'h2);
    check("t6_wr1", 32'(obs_wr), 1);
    cycle();
    check("t6_drop_grant", 32'(obs_grant), 32'h2);
    check("t6_drop_no_wr", 32'(obs_wr), 0);
    repeat (2) begin
      cycle();
      check("t6_grant3", 32'(obs_grant), 32'h8);
      check("t6_wr3", 32'(obs_wr), 1);
    end
    cycle();
    check("t6_tail_wr", 32'(obs_wr), 0);
    cycle();
    check("t6_end_grant", 32'(obs_grant), 0);
    check("t6_end_ptr", 32'(obs_ptr), 0);
    check("t6_drained", 32'(exp_q.size()), 0);

    // Reset during req3 burst at beat 2, then req1 wins from pointer 0
    load(3, 8'h71, 8'h01, 4, 1'b0);
    push_seq(8'h71, 8'h01, 2);
    push_seq(8'h81, 8'h00, 1);
    push_seq(8'h73, 8'h01, 2);
    cycle();
    check("t5_idle_grant", 32'(obs_grant), 0);
    repeat (2) begin
      cycle();
      check("t5_grant3", 32'(obs_grant), 32'h8);
      check("t5_wr3", 32'(obs_wr), 1);
    end
    i_rst = 1'b1;
    load(1, 8'h81, 8'h00, 1, 1'b1);
    cycle();
    check("t5_rst_cycle_wr", 32'(obs_wr), 0);
    i_rst = 1'b0;
    cycle();
    check("t5_after_rst_grant", 32'(obs_grant), 0);
    check("t5_after_rst_busy", 32'(obs_busy), 0);
    check("t5_after_rst_wr", 32'(obs_wr), 0);
    check("t5_after_rst_ptr", 32'(obs_ptr), 0);
    cycle();
    check("t5_grant1", 32'(obs_grant), 32'h2);
    check("t5_wr1", 32'(obs_wr), 1);
    repeat (2) begin
      cycle();
      check("t5_regrant3", 32'(obs_grant), 32'h8);
      check("t5_rewr3", 32'(obs_wr), 1);
    end
    cycle();
    check("t5_tail_wr", 32'(obs_wr), 0);
    cycle();
    check("t5_end_grant", 32'(obs_grant), 0);
    check("t5_end_busy", 32'(obs_busy), 0);
    check("t5_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
